// File: rtl/team_06_volume_shifter.sv
// team_06_volume_shifter
// Speaker-path volume stage: debounced-edge volume buttons, mute/listen
// gating, and a two-stage scale pipeline (multiply, then shift/saturate).
// Gain step is 0.25, so gain 4 is unity.
// Optional feature: define SOFT_RAMP_EN to make the applied gain walk toward
// its target one step per sample instead of jumping in a single sample.
module team_06_volume_shifter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] spk_aud,
   input  logic       spk_valid,
   input  logic       vol_en,
   input  logic       mute_tog,
   input  logic       vol_up,
   input  logic       vol_down,
   output logic [7:0] spk_out,
   output logic       spk_out_valid,
   output logic [2:0] vol_level,
   output logic [2:0] gain_eff
);

   typedef enum logic [1:0] {
      STEADY    = 2'd0,
      RAMP_DOWN = 2'd1,
      RAMP_UP   = 2'd2
   } ramp_t;

   // ------------------------------------------------------------------
   // Button edge detection: bit 0 = vol_up, bit 1 = vol_down
   // ------------------------------------------------------------------
   logic [1:0] btn_raw;
   logic [1:0] btn_prev1;
   logic [1:0] btn_prev2;
   logic [1:0] btn_rise;

   assign btn_raw = {vol_down, vol_up};

   // Two-deep history per button; cleared so a button held through reset
   // still produces one rise after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev1 <= 2'b00;
         btn_prev2 <= 2'b00;
      end else begin
         btn_prev1 <= btn_raw;
         btn_prev2 <= btn_prev1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rise
         assign btn_rise[gi] = btn_prev1[gi] & ~btn_prev2[gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // User volume step
   // ------------------------------------------------------------------
   // Saturating up/down counter; simultaneous rises cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vol_level <= 3'd4;
      end else if (btn_rise[0] && !btn_rise[1] && (vol_level != 3'd7)) begin
         vol_level <= vol_level + 3'd1;
      end else if (btn_rise[1] && !btn_rise[0] && (vol_level != 3'd0)) begin
         vol_level <= vol_level - 3'd1;
      end
   end

   logic [2:0] target_gain;
   assign target_gain = (vol_en && !mute_tog) ? vol_level : 3'd0;

   // ------------------------------------------------------------------
   // Applied gain and ramp state
   // ------------------------------------------------------------------
   ramp_t      ramp_state;
   ramp_t      ramp_next;
   logic [2:0] gain_next;

   // Gain and ramp state only advance on sample strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ramp_state <= STEADY;
         gain_eff   <= 3'd0;
      end else begin
         ramp_state <= ramp_next;
         gain_eff   <= gain_next;
      end
   end

   // Direction is re-evaluated on every strobe, so a target change mid-ramp
   // turns the ramp around on the next sample.
   always_comb begin
      ramp_next = ramp_state;
      gain_next = gain_eff;
`ifdef SOFT_RAMP_EN
      if (spk_valid) begin
         if (gain_eff > target_gain) begin
            ramp_next = RAMP_DOWN;
            gain_next = gain_eff - 3'd1;
         end else if (gain_eff < target_gain) begin
            ramp_next = RAMP_UP;
            gain_next = gain_eff + 3'd1;
         end else begin
            ramp_next = STEADY;
         end
      end
`else
      ramp_next = STEADY;
      if (spk_valid) begin
         gain_next = target_gain;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Stage 1: signed sample times gain
   // ------------------------------------------------------------------
   // The product uses the gain that becomes gain_eff on this strobe, so a
   // sample and the gain reported for it always agree.
   logic signed [7:0]  sample_s;
   logic signed [10:0] sample_ext;
   logic signed [10:0] gain_ext;
   logic signed [10:0] prod_next;
   logic signed [10:0] prod;
   logic               stage1_valid;

   assign sample_s   = spk_aud ^ 8'h80;
   assign sample_ext = {{3{sample_s[7]}}, sample_s};
   assign gain_ext   = {8'd0, gain_next};
   assign prod_next  = sample_ext * gain_ext;

   // Product register plus its valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod         <= 11'sd0;
         stage1_valid <= 1'b0;
      end else begin
         stage1_valid <= spk_valid;
         if (spk_valid) begin
            prod <= prod_next;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: scale by 1/4, saturate, re-centre on 128
   // ------------------------------------------------------------------
   logic signed [10:0] shifted;
   logic [7:0]         sat_byte;

   // Arithmetic shift then clamp to the signed 8-bit range.
   always_comb begin
      shifted = prod >>> 2;
      if (shifted > 11'sd127) begin
         sat_byte = 8'h7F;
      end else if (shifted < -11'sd128) begin
         sat_byte = 8'h80;
      end else begin
         sat_byte = shifted[7:0];
      end
   end

   // Output register holds its value between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spk_out       <= 8'd128;
         spk_out_valid <= 1'b0;
      end else begin
         spk_out_valid <= stage1_valid;
         if (stage1_valid) begin
            spk_out <= sat_byte ^ 8'h80;
         end
      end
   end

endmodule

// File: tb/tb_team_06_volume_shifter.sv
// Testbench for team_06_volume_shifter: a cycle-level reference model is
// compared with the DUT every cycle, alongside a table of fixed vectors and
// hand-written sequences for reset, ramp and button corner cases.
module tb_team_06_volume_shifter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] spk_aud = 8'd128;
   logic       spk_valid = 1'b0;
   logic       vol_en = 1'b1;
   logic       mute_tog = 1'b0;
   logic       vol_up = 1'b0;
   logic       vol_down = 1'b0;
   logic [7:0] spk_out;
   logic       spk_out_valid;
   logic [2:0] vol_level;
   logic [2:0] gain_eff;

   always #5 clk = ~clk;

   team_06_volume_shifter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .spk_aud       (spk_aud),
      .spk_valid     (spk_valid),
      .vol_en        (vol_en),
      .mute_tog      (mute_tog),
      .vol_up        (vol_up),
      .vol_down      (vol_down),
      .spk_out       (spk_out),
      .spk_out_valid (spk_out_valid),
      .vol_level     (vol_level),
      .gain_eff      (gain_eff)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct {
      int due;
      int val;
   } pend_t;

   pend_t pend[$];
   int m_level, m_gain, m_out, m_valid;
   int up_s1, up_s2, dn_s1, dn_s2;
   int edge_n = 0;

   // Output value from plain arithmetic: floor(s*g/4), clamped, +128.
   function automatic int ref_out(input int aud, input int g);
      int p, q;
      p = (aud - 128) * g;
      if (p >= 0) q = p / 4;
      else q = -((-p + 3) / 4);
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q + 128;
   endfunction

   task automatic model_reset();
      m_level = 4; m_gain = 0; m_out = 128; m_valid = 0;
      up_s1 = 0; up_s2 = 0; dn_s1 = 0; dn_s2 = 0;
      pend.delete();
   endtask

   // One rising edge of the model, using the inputs held during the cycle.
   task automatic model_edge();
      int    target;
      bit    rise_up, rise_dn;
      pend_t t;
      m_valid = 0;
      if (pend.size() > 0 && pend[0].due == edge_n) begin
         t = pend.pop_front();
         m_out = t.val;
         m_valid = 1;
      end
      target = (vol_en && !mute_tog) ? m_level : 0;
      if (spk_valid) begin
`ifdef SOFT_RAMP_EN
         if (m_gain < target) m_gain++;
         else if (m_gain > target) m_gain--;
`else
         m_gain = target;
`endif
         // Strobe seen at edge k shows up after edge k+1: two cycles after
         // the cycle in which spk_valid was high.
         t.due = edge_n + 1;
         t.val = ref_out(int'(spk_aud), m_gain);
         pend.push_back(t);
      end
      rise_up = (up_s1 == 1) && (up_s2 == 0);
      rise_dn = (dn_s1 == 1) && (dn_s2 == 0);
      if (rise_up && !rise_dn && m_level < 7) m_level++;
      else if (rise_dn && !rise_up && m_level > 0) m_level--;
      up_s2 = up_s1; up_s1 = int'(vol_up);
      dn_s2 = dn_s1; dn_s1 = int'(vol_down);
      edge_n++;
   endtask

   task automatic compare_all();
      chk("spk_out_valid", int'(spk_out_valid), m_valid);
      chk("spk_out", int'(spk_out), m_out);
      chk("vol_level", int'(vol_level), m_level);
      chk("gain_eff", int'(gain_eff), m_gain);
   endtask

   // Inputs are changed at the falling edge; outputs are compared there too.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic press(input bit up, input int n);
      for (int i = 0; i < n; i++) begin
         if (up) vol_up = 1'b1; else vol_down = 1'b1;
         tick();
         vol_up = 1'b0; vol_down = 1'b0;
         tick();
         tick();
      end
   endtask

   task automatic goto_level(input int lvl);
      for (int i = 0; i < 8 && m_level != lvl; i++) begin
         press(m_level < lvl, 1);
      end
      chk("goto_level", int'(vol_level), lvl);
   endtask

   // Strobe silence until the applied gain reaches the target (bounded).
   task automatic settle();
      int tgt;
      tgt = (vol_en && !mute_tog) ? m_level : 0;
      spk_aud = 8'd128;
      for (int i = 0; i < 12 && int'(gain_eff) != tgt; i++) begin
         spk_valid = 1'b1;
         tick();
      end
      spk_valid = 1'b0;
      tick();
      tick();
      chk("settle_gain", int'(gain_eff), tgt);
   endtask

   typedef struct {
      int level;
      int aud;
      int exp_out;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int expg[5];
      int expo[5];
      int stray;

      vecs[0]  = '{4, 200, 200};
      vecs[1]  = '{4,   0,   0};
      vecs[2]  = '{4, 255, 255};
      vecs[3]  = '{4, 128, 128};
      vecs[4]  = '{7, 255, 255};
      vecs[5]  = '{7,   0,   0};
      vecs[6]  = '{7, 150, 166};
      vecs[7]  = '{7, 100,  79};
      vecs[8]  = '{2, 200, 164};
      vecs[9]  = '{2,   1,  64};
      vecs[10] = '{0, 255, 128};
      vecs[11] = '{0,   3, 128};

      // ---------------- reset state ----------------
      model_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_spk_out", int'(spk_out), 128);
      chk("rst_valid", int'(spk_out_valid), 0);
      chk("rst_vol_level", int'(vol_level), 4);
      chk("rst_gain_eff", int'(gain_eff), 0);
      rst_n = 1'b1;

      // ---------------- unity-gain settling, sample 200 ----------------
      vol_en = 1'b1; mute_tog = 1'b0;
      spk_aud = 8'd200; spk_valid = 1'b1;
      tick();
      spk_valid = 1'b0;
      tick();
      chk("first_valid", int'(spk_out_valid), 1);
`ifdef SOFT_RAMP_EN
      chk("first_out", int'(spk_out), 146);
`else
      chk("first_out", int'(spk_out), 200);
`endif
      spk_valid = 1'b1;
      repeat (6) tick();
      spk_valid = 1'b0;
      tick();
      chk("settled_out", int'(spk_out), 200);
      chk("settled_gain", int'(gain_eff), 4);
      $display("seq settle: spk_out=%0d gain_eff=%0d", spk_out, gain_eff);

      // ---------------- simultaneous rises at level 4 ----------------
      vol_up = 1'b1; vol_down = 1'b1;
      tick();
      vol_up = 1'b0; vol_down = 1'b0;
      tick();
      tick();
      chk("simul_level", int'(vol_level), 4);
      $display("seq simultaneous press: vol_level=%0d", vol_level);

      // ---------------- mute ramp from gain 4, strobe every cycle ----------------
`ifdef SOFT_RAMP_EN
      expg = '{3, 2, 1, 0, 0};
      expo = '{152, 144, 136, 128, 128};
`else
      expg = '{0, 0, 0, 0, 0};
      expo = '{128, 128, 128, 128, 128};
`endif
      mute_tog = 1'b1; spk_aud = 8'd160; spk_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("ramp_gain", int'(gain_eff), expg[j]);
         if (j >= 1) chk("ramp_out", int'(spk_out), expo[j-1]);
      end
      spk_valid = 1'b0;
      tick();
      chk("ramp_out", int'(spk_out), expo[4]);
      $display("seq mute ramp: final spk_out=%0d gain_eff=%0d", spk_out, gain_eff);
      mute_tog = 1'b0;
      settle();

      // ---------------- level saturation ----------------
      press(1'b0, 8);
      chk("level_floor", int'(vol_level), 0);
      $display("seq 8x down: vol_level=%0d", vol_level);
      press(1'b1, 10);
      chk("level_ceiling", int'(vol_level), 7);
      $display("seq 10x up: vol_level=%0d", vol_level);

      // ---------------- table vectors ----------------
      for (int i = 0; i < 12; i++) begin
         goto_level(vecs[i].level);
         settle();
         spk_aud = 8'(vecs[i].aud);
         spk_valid = 1'b1;
         tick();
         spk_valid = 1'b0;
         tick();
         chk("tbl_valid", int'(spk_out_valid), 1);
         chk("tbl_out", int'(spk_out), vecs[i].exp_out);
         $display("vec %0d: level=%0d aud=%0d spk_out=%0d expect=%0d",
                  i, vecs[i].level, vecs[i].aud, spk_out, vecs[i].exp_out);
      end

      // ---------------- reset with a sample in flight ----------------
      goto_level(4);
      settle();
      spk_aud = 8'd200; spk_valid = 1'b1;
      tick();
      spk_valid = 1'b0;
      vol_up = 1'b1;            // held through reset
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("inflight_rst_valid", int'(spk_out_valid), 0);
      chk("inflight_rst_out", int'(spk_out), 128);
      tick();
      tick();
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         stray += int'(spk_out_valid);
      end
      chk("no_stray_valid", stray, 0);
      chk("held_btn_level", int'(vol_level), 5);
      vol_up = 1'b0;
      tick();
      $display("seq in-flight reset: stray=%0d vol_level=%0d", stray, vol_level);

      // ---------------- randomized run against the model ----------------
      for (int c = 0; c < 2000; c++) begin
         spk_valid = ($urandom_range(9) < 6);
         spk_aud = 8'($urandom_range(255));
         if ($urandom_range(29) == 0) mute_tog = ~mute_tog;
         if ($urandom_range(79) == 0) vol_en = ~vol_en;
         if ($urandom_range(5) == 0) vol_up = ~vol_up;
         if ($urandom_range(5) == 0) vol_down = ~vol_down;
         if (c == 1000) begin
            rst_n = 1'b0;
            model_reset();
            tick();
            tick();
            rst_n = 1'b1;
         end
         tick();
      end
      spk_valid = 1'b0; vol_up = 1'b0; vol_down = 1'b0;
      tick();
      tick();
      $display("random run: 2000 cycles done");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
